// File: rtl/ex_divider_if.sv
// ex_divider_if: EX-stage divide request/result bundle between pipeline and divider
interface ex_divider_if;
    logic        start;
    logic        flush;
    logic        hold;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  f;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    modport master (output start, flush, hold, op1, op2, f, input busy, valid, result);
    modport slave (input start, flush, hold, op1, op2, f, output busy, valid, result);
endinterface

// File: rtl/ex_divider.sv
// ex_divider: iterative radix-2 RV32M DIV/DIVU/REM/REMU unit with pipeline stall
module ex_divider (
    input logic         clk,
    input logic         rst_n,
    ex_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] q, dvs, rem, result;
    logic        neg_q, neg_r;
    logic [1:0]  fn;
    logic [31:0] a_abs, b_abs, q_n, rem_n, quo, rmd;
    logic [32:0] rem_s, trial;
    logic        sgn, load, dz, ovf;
    always_comb begin
        sgn = ~bus.f[0];
        a_abs = (sgn && bus.op1[31]) ? -bus.op1 : bus.op1;
        b_abs = (sgn && bus.op2[31]) ? -bus.op2 : bus.op2;
        load = state == IDLE && bus.start && !bus.flush;
        dz = bus.op2 == 32'd0;
        ovf = sgn && bus.op1 == 32'h8000_0000 && bus.op2 == 32'hFFFF_FFFF;
        rem_s = {rem, q[31]};
        trial = rem_s - {1'b0, dvs};
        rem_n = trial[32] ? rem_s[31:0] : trial[31:0];
        q_n = {q[30:0], ~trial[32]};
        quo = neg_q ? -q_n : q_n;
        rmd = neg_r ? -rem_n : rem_n;
    end
    assign bus.busy = load || state == CALC;
    assign bus.valid = state == DONE && !bus.flush;
    assign bus.result = result;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= 6'd0;
            q <= 32'd0;
            dvs <= 32'd0;
            rem <= 32'd0;
            result <= 32'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            fn <= 2'd0;
        end else if (bus.flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    fn <= bus.f;
                    neg_q <= sgn & (bus.op1[31] ^ bus.op2[31]);
                    neg_r <= sgn & bus.op1[31];
                    q <= a_abs;
                    dvs <= b_abs;
                    rem <= 32'd0;
                    cnt <= 6'd32;
                    // divide-by-zero and signed overflow bypass the iteration entirely
                    if (dz || ovf) begin
                        state <= DONE;
                        result <= bus.f[1] ? (dz ? bus.op1 : 32'd0) : (dz ? 32'hFFFF_FFFF : 32'h8000_0000);
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_n;
                    q <= q_n;
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        state <= DONE;
                        result <= fn[1] ? rmd : quo;
                    end
                end
                DONE: if (!bus.hold) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_divider.sv
// tb_ex_divider: directed-vector self-checking bench for ex_divider
module tb_ex_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    ex_divider_if bus ();
    ex_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a divide in the current cycle and waits until the busy window closes,
    // leaving the bench in the DONE cycle with start still high.
    task automatic run(input string tag, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int ncyc);
        int cyc = 0;
        bus.f = f;
        bus.op1 = a;
        bus.op2 = b;
        bus.start = 1'b1;
        #1;
        check({tag, " busy@C"}, {31'd0, bus.busy}, 32'd1);
        tick;
        bus.op1 = 32'hDEAD_BEEF;
        bus.op2 = 32'h0000_0003;
        cyc = 1;
        while (bus.busy && cyc < 40) begin
            tick;
            cyc++;
        end
        check({tag, " cycles"}, cyc, ncyc);
        check({tag, " valid"}, {31'd0, bus.valid}, 32'd1);
        check({tag, " busy@done"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " result"}, bus.result, exp);
    endtask

    task automatic advance;
        bus.start = 1'b0;
        tick;
        check("idle valid", {31'd0, bus.valid}, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.hold = 1'b0;
        bus.op1 = 32'd0;
        bus.op2 = 32'd0;
        bus.f = 2'd0;
        #1 rst_n = 1'b0;
        #1;
        check("rst result", bus.result, 32'd0);
        check("rst valid", {31'd0, bus.valid}, 32'd0);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        run("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 33); advance;
        run("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 33); advance;
        run("div -7/2", 2'b00, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33); advance;
        run("rem -7/2", 2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33); advance;
        run("rem 7/-2", 2'b10, 32'd7, -32'sd2, 32'd1, 33); advance;
        run("div 7/-2", 2'b00, 32'd7, -32'sd2, 32'hFFFF_FFFD, 33); advance;
        run("divu big", 2'b01, 32'hFFFF_FFF0, 32'h10, 32'h0FFF_FFFF, 33); advance;
        run("remu big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33); advance;
        run("divu 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1); advance;
        run("remu 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 1); advance;
        run("div -5/0", 2'b00, -32'sd5, 32'd0, 32'hFFFF_FFFF, 1); advance;
        run("rem -5/0", 2'b10, -32'sd5, 32'd0, 32'hFFFF_FFFB, 1); advance;
        run("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); advance;
        run("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1); advance;
        run("divu ovf ops", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33); advance;

        // flush mid-calculation, then a fresh divide in the following IDLE cycle
        bus.f = 2'b01;
        bus.op1 = 32'd100;
        bus.op2 = 32'd7;
        bus.start = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        bus.flush = 1'b1;
        #1;
        check("flush valid", {31'd0, bus.valid}, 32'd0);
        tick;
        bus.flush = 1'b0;
        check("post flush valid", {31'd0, bus.valid}, 32'd0);
        run("divu 9/3 after flush", 2'b01, 32'd9, 32'd3, 32'd3, 33);

        // hold in DONE keeps the result presented, then back-to-back accept
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("hold valid", {31'd0, bus.valid}, 32'd1);
            check("hold result", bus.result, 32'd3);
            check("hold busy", {31'd0, bus.busy}, 32'd0);
        end
        bus.hold = 1'b0;
        tick;
        run("divu 50/5 back2back", 2'b01, 32'd50, 32'd5, 32'd10, 33); advance;

        // flush and start together in IDLE: flush wins
        bus.f = 2'b01;
        bus.op1 = 32'd8;
        bus.op2 = 32'd0;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        #1;
        check("flush+start busy", {31'd0, bus.busy}, 32'd0);
        tick;
        check("flush+start valid", {31'd0, bus.valid}, 32'd0);
        check("flush keeps result", bus.result, 32'd10);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        tick;

        // asynchronous reset mid-operation returns to IDLE
        run("pre-reset divu 9/3", 2'b01, 32'd9, 32'd3, 32'd3, 33); advance;
        bus.op1 = 32'd100;
        bus.op2 = 32'd7;
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        bus.start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset busy", {31'd0, bus.busy}, 32'd0);
        check("midreset result", bus.result, 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        check("post reset valid", {31'd0, bus.valid}, 32'd0);
        run("divu 100/7 after reset", 2'b01, 32'd100, 32'd7, 32'd14, 33); advance;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_divider.md
# ex_divider

Iterative radix-2 integer divider for the EX stage. It consumes the prepared operands and function code that the OP stage registers into OPEX, and executes RV32M DIV, DIVU, REM and REMU. While it works it asserts a stall toward the lower stages, then presents a 32-bit result for one pipeline advance. It has one non-replicated instance per EX datapath copy.

## Interface
- W, 32, operand/result width; only 32 is supported.
- s_clk_i  in  1  clock.
- s_resetn_i  in  1  asynchronous active-low reset.
- s_start_i  in  1  a valid divide instruction occupies EX; held high while the instruction stays in EX.
- s_flush_i  in  1  EX-stage flush from MA; aborts the operation.
- s_hold_i  in  1  stall from MA/WB; the pipeline will not advance this cycle.
- s_op1_i  in  W  dividend (OPEX operand 1).
- s_op2_i  in  W  divisor (OPEX operand 2).
- s_f_i  in  2  function: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- s_busy_o  out  1  stall request to lower stages; combinational.
- s_valid_o  out  1  s_result_o is valid this cycle.
- s_result_o  out  W  quotient or remainder.

## Operation
- States: IDLE, CALC, DONE. State register, 6-bit iteration counter, 32-bit quotient/dividend shift register, 33-bit partial remainder, sign flags and function latch.
- IDLE: when s_start_i & ~s_flush_i, latch the operands and function at the clock edge.
  - Signed ops (f[0]=0): store |op1| and |op2|.
  - neg_q = op1[31]^op2[31]; neg_r = op1[31].
  - Unsigned ops: neg_q = neg_r = 0.
- Special cases are decided at load and go IDLE→DONE directly:
  - Divisor 0: quotient 0xFFFFFFFF, remainder op1.
  - DIV/REM with op1=0x80000000 and op2=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Otherwise IDLE→CALC, with counter set to 32.
- CALC, each edge:
  - rem' = {rem[31:0], q[31]}; trial = rem' − divisor (33-bit).
  - If trial is non-negative: rem=trial and shift 1 into q. Else rem=rem' and shift 0 into q.
  - Decrement the counter. When counter=1, go to DONE.
- DONE, on the transition into DONE: s_result_o is registered as
  - quotient (f[1]=0) or remainder (f[1]=1),
  - two's-complement negated if the matching neg flag is set.
- DONE, while held: stay in DONE while s_hold_i=1 and s_flush_i=0; the result stays stable.
- DONE, on leaving: go to IDLE when s_hold_i=0. s_start_i in DONE is never treated as a new operation.
- s_busy_o = (IDLE & s_start_i & ~s_flush_i) | CALC.
- s_valid_o = DONE & ~s_flush_i.
- Flush: s_flush_i in any state forces IDLE at the next edge. The load in IDLE is suppressed and no valid is produced. s_result_o keeps its last value.
- Operand changes on s_op1_i/s_op2_i after the load cycle are ignored.

## Timing
- Reset (asynchronous, any state) sets:
  - state IDLE, counter 0, all datapath registers 0;
  - s_result_o = 0, s_valid_o = 0, s_busy_o = 0 (with s_start_i low).
- Normal operation, with start first seen in IDLE at cycle C:
  - s_busy_o=1 in cycles C..C+32;
  - CALC occupies C+1..C+32 (32 iterations);
  - DONE at C+33 with s_valid_o=1 and s_busy_o=0;
  - the pipeline advances at the end of C+33 if s_hold_i=0.
- Special cases: s_busy_o=1 only in cycle C; DONE at C+1.
- Back-to-back divides: DONE→IDLE costs one cycle. The next divide's start is sampled in IDLE at C+34, or later if held.
- Flush and start in the same cycle: the flush wins.
- Reset released mid-operation: the block returns to IDLE; the instruction is reissued by the pipeline.

## Test plan
- DIVU 100/7 at cycle C → s_busy_o high C..C+32; s_valid_o=1, s_result_o=14 at C+33. REMU of the same operands → 2.
- DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). REM 7/−2 → 1.
- DIVU 5/0 → 0xFFFFFFFF at C+1. REMU 5/0 → 5. DIV −5/0 → 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 at C+1. REM of the same operands → 0.
- Flush at C+10 → IDLE at C+11 and no s_valid_o. A new DIVU 9/3 started at C+11 → valid 3 at C+44.
- s_hold_i high for 3 cycles in DONE → s_result_o is stable and s_valid_o stays 1. Then s_hold_i drops → IDLE next cycle, and a second divide is accepted in that IDLE cycle.
